// File: rtl/mult_div_unit_if.sv
// Request/result bundle for the iterative multiply/divide unit.
// Master drives operands and direct writes; slave returns Hi/Lo and status.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             WrHi;
    logic             WrLo;
    logic [WIDTH-1:0] WrData;
    logic             Busy;
    logic             Done;
    logic             DivByZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, OpA, OpB, WrHi, WrLo, WrData,
        input  Busy, Done, DivByZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, OpA, OpB, WrHi, WrLo, WrData,
        output Busy, Done, DivByZero, Hi, Lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Radix-2 shift-add multiplier / restoring divider with Hi/Lo registers.
// Fixed 33-cycle busy window: 32 RUN iterations plus one FIX cycle.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input logic             Clk,
    input logic             Reset_n,
    mult_div_unit_if.slave  bus
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_div;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_p;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_sgn;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_mstep;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_dstep;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_bz;

    assign w_sgn   = bus.Op[0];
    assign w_a_neg = w_sgn & bus.OpA[WIDTH-1];
    assign w_b_neg = w_sgn & bus.OpB[WIDTH-1];
    assign w_a_abs = w_a_neg ? -bus.OpA : bus.OpA;
    assign w_b_abs = w_b_neg ? -bus.OpB : bus.OpB;

    // Multiply: {acc, multiplier} shifts right, adding r_b on a set LSB
    assign w_madd  = {1'b0, r_p[2*WIDTH-1:WIDTH]}
                   + (r_p[0] ? {1'b0, r_b} : '0);
    assign w_mstep = {w_madd, r_p[WIDTH-1:1]};

    // Divide: {rem, quotient} shifts left, trial-subtracting r_b
    assign w_shift = r_p[2*WIDTH-1:WIDTH-1];
    assign w_diff  = w_shift - {1'b0, r_b};
    assign w_ge    = (w_shift >= {1'b0, r_b});
    assign w_dstep = {w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0],
                      r_p[WIDTH-2:0], w_ge};

    assign w_prod = r_neg_q ? -r_p : r_p;
    assign w_quo  = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
    assign w_bz   = (r_b == '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_b     <= '0;
            r_p     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.WrHi) r_hi <= bus.WrData;
                    if (bus.WrLo) r_lo <= bus.WrData;
                    if (bus.Start) begin
                        r_state <= S_RUN;
                        r_div   <= bus.Op[1];
                        r_b     <= w_b_abs;
                        r_p     <= {{WIDTH{1'b0}}, w_a_abs};
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_dbz   <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_p   <= r_div ? w_dstep : w_mstep;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(ITER - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    // With a zero divisor the remainder path ends holding |OpA|,
                    // so the dividend-sign fix restores the raw OpA into Hi
                    if (!r_div) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end else begin
                        r_hi  <= w_rem;
                        r_lo  <= w_bz ? '1 : w_quo;
                        r_dbz <= w_bz;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Busy      = r_busy;
    assign bus.Done      = r_done;
    assign bus.DivByZero = r_dbz;
    assign bus.Hi        = r_hi;
    assign bus.Lo        = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against a cycle-level arithmetic model.
// Directed scenarios pin the model with hand-computed literals.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_div_unit_if ifc ();

    mult_div_unit dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (ifc)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from the arithmetic rules
    function automatic void ref_op(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] hi,
                                   output logic [31:0] lo, output logic dz);
        logic [63:0] pu;
        longint sa, sb, ps, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        case (op)
            2'b00: begin
                pu = {32'b0, a} * {32'b0, b};
                hi = pu[63:32];
                lo = pu[31:0];
            end
            2'b01: begin
                ps = sa * sb;
                pu = ps;
                hi = pu[63:32];
                lo = pu[31:0];
            end
            2'b10: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF; hi = a; dz = 1'b1;
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
            default: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF; hi = a; dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 32'h0;
                end else begin
                    q = sa / sb; r = sa % sb;
                    lo = 32'(q); hi = 32'(r);
                end
            end
        endcase
    endfunction

    // Model: cycles left in the busy window plus the pending result
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_hi = '0; m_lo = '0;
            m_done = 1'b0; m_dbz = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz; m_done = 1'b1;
                end
            end else begin
                if (ifc.WrHi) m_hi = ifc.WrData;
                if (ifc.WrLo) m_lo = ifc.WrData;
                if (ifc.Start) begin
                    ref_op(ifc.Op, ifc.OpA, ifc.OpB, p_hi, p_lo, p_dbz);
                    m_left = 33;
                    m_dbz = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ctl{busy,done,dbz}",
                {29'b0, ifc.Busy, ifc.Done, ifc.DivByZero},
                {29'b0, (m_left > 0), m_done, m_dbz});
            chk("hi", ifc.Hi, m_hi);
            chk("lo", ifc.Lo, m_lo);
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        ifc.Start = 1'b1; ifc.Op = op; ifc.OpA = a; ifc.OpB = b;
        @(posedge clk); #1;
        ifc.Start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ifc.Done && n < 40);
        if (!ifc.Done) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: got no Done within %0d cycles", n);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, extra;
        ifc.Start = 0; ifc.Op = 0; ifc.OpA = 0; ifc.OpB = 0;
        ifc.WrHi = 0; ifc.WrLo = 0; ifc.WrData = 0;

        #8;
        chk("rst_ctl", {29'b0, ifc.Busy, ifc.Done, ifc.DivByZero}, 32'h0);
        chk("rst_hi", ifc.Hi, 32'h0);
        chk("rst_lo", ifc.Lo, 32'h0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        chk("latency", n, 33);
        chk("multu_hi", ifc.Hi, 32'hFFFF_FFFE);
        chk("multu_lo", ifc.Lo, 32'h0000_0001);

        start_op(2'b01, 32'hFFFF_FFFD, 32'd7);
        wait_done(n);
        chk("mult_hi", ifc.Hi, 32'hFFFF_FFFF);
        chk("mult_lo", ifc.Lo, 32'hFFFF_FFEB);
        start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        chk("b2b_latency", n, 33);
        chk("div_lo", ifc.Lo, 32'hFFFF_FFFD);
        chk("div_hi", ifc.Hi, 32'hFFFF_FFFF);

        start_op(2'b10, 32'd100, 32'd0);
        wait_done(n);
        chk("dbz_lo", ifc.Lo, 32'hFFFF_FFFF);
        chk("dbz_hi", ifc.Hi, 32'h0000_0064);
        chk("dbz_flag", {31'b0, ifc.DivByZero}, 32'h1);
        start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        chk("ovf_lo", ifc.Lo, 32'h8000_0000);
        chk("ovf_hi", ifc.Hi, 32'h0);
        chk("ovf_dbz", {31'b0, ifc.DivByZero}, 32'h0);

        start_op(2'b00, 32'd5, 32'd6);
        repeat (4) begin @(posedge clk); #1; end
        repeat (6) begin
            ifc.Start = 1'b1; ifc.Op = 2'($urandom);
            ifc.OpA = $urandom; ifc.OpB = $urandom;
            ifc.WrHi = 1'b1; ifc.WrData = 32'hDEAD_BEEF;
            @(posedge clk); #1;
        end
        ifc.Start = 0; ifc.WrHi = 0;
        wait_done(n);
        chk("ign_hi", ifc.Hi, 32'h0);
        chk("ign_lo", ifc.Lo, 32'd30);
        extra = 0;
        repeat (40) begin @(posedge clk); #1; if (ifc.Done) extra++; end
        chk("extra_done", extra, 0);

        start_op(2'b10, 32'd1000, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ctl", {29'b0, ifc.Busy, ifc.Done, ifc.DivByZero}, 32'h0);
        chk("arst_hi", ifc.Hi, 32'h0);
        chk("arst_lo", ifc.Lo, 32'h0);
        #2 rst_n = 1'b1;
        extra = 0;
        repeat (40) begin @(posedge clk); #1; if (ifc.Done) extra++; end
        chk("ghost_done", extra, 0);
        start_op(2'b10, 32'd1000, 32'd7);
        wait_done(n);
        chk("divu_lo", ifc.Lo, 32'd142);
        chk("divu_hi", ifc.Hi, 32'd6);

        ifc.WrLo = 1'b1; ifc.WrData = 32'h1234_5678;
        @(posedge clk); #1;
        ifc.WrLo = 1'b0;
        chk("wrlo_lo", ifc.Lo, 32'h1234_5678);
        chk("wrlo_hi", ifc.Hi, 32'd6);
        ifc.WrHi = 1'b1; ifc.WrLo = 1'b1; ifc.WrData = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        ifc.WrHi = 1'b0; ifc.WrLo = 1'b0;
        chk("wrboth_hi", ifc.Hi, 32'hA5A5_A5A5);
        chk("wrboth_lo", ifc.Lo, 32'hA5A5_A5A5);

        repeat (3000) begin
            ifc.Start  = ($urandom_range(0, 3) == 0);
            ifc.Op     = 2'($urandom);
            ifc.OpA    = pick();
            ifc.OpB    = pick();
            ifc.WrHi   = ($urandom_range(0, 7) == 0);
            ifc.WrLo   = ($urandom_range(0, 7) == 0);
            ifc.WrData = $urandom;
            @(posedge clk); #1;
        end
        ifc.Start = 0; ifc.WrHi = 0; ifc.WrLo = 0;
        repeat (40) begin @(posedge clk); #1; end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit with architectural Hi/Lo registers.
- Sits directly downstream of the operand-select 2:1 muxes in the execute stage. Consumes the selected 32-bit operands and returns 64-bit products and quotient/remainder pairs.
- Replaces a combinational multiplier/divider. A radix-2 shift-add/shift-subtract datapath with a fixed 33-cycle busy window is used instead.

Parameters:
- WIDTH, 32, operand width; Hi/Lo are WIDTH each.
- ITER, 32, iteration count in RUN; must equal WIDTH.

Ports:
- Clk  input  1  single system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- OpA  input  32  multiplicand/dividend (operand-select mux output).
- OpB  input  32  multiplier/divisor (operand-select mux output).
- WrHi  input  1  direct write of Hi (move-to-Hi).
- WrLo  input  1  direct write of Lo (move-to-Lo).
- WrData  input  32  data for WrHi/WrLo.
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle pulse when Hi/Lo hold a new result.
- DivByZero  output  1  valid with Done; set for DIV/DIVU with OpB=0.
- Hi  output  32  Hi register (product high word / remainder).
- Lo  output  32  Lo register (product low word / quotient).

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - State=IDLE; Hi=Lo=0; Busy=Done=DivByZero=0.
  - The in-flight operation is discarded and no Done is issued.
- FSM states: IDLE, RUN, FIX.
  - IDLE→RUN on a rising edge with Start=1. At that edge: OpA, OpB and Op are latched, the iteration counter is cleared, Busy goes 1, and DivByZero is cleared.
  - RUN: one iteration per cycle for exactly ITER cycles; after the 32nd iteration, go to FIX.
  - FIX: sign correction and special-case selection. At the FIX edge Hi/Lo are written, Done=1 for the following cycle only, Busy=0, and state returns to IDLE.
- Latency: Busy high for exactly 33 cycles. Done is high in the first cycle after Busy falls, coincident with the new Hi/Lo.
- Start while Busy=1 is ignored; no queueing. Start in the Done cycle is accepted, giving back-to-back operation.
- Operand changes after the Start edge have no effect.
- Signed ops (MULT, DIV):
  - Operate on absolute values and correct the sign in FIX.
  - MULT: {Hi,Lo} = 64-bit two's-complement product.
  - DIV: quotient truncates toward zero (Lo); remainder takes the sign of the dividend (Hi).
- Unsigned ops: {Hi,Lo} = OpA*OpB; Lo = OpA/OpB; Hi = OpA%OpB.
- Divide by zero (DIV or DIVU with OpB=0):
  - Still takes the full 33 cycles.
  - Lo=32'hFFFFFFFF, Hi=OpA (latched), DivByZero=1 alongside Done; DivByZero holds until the next accepted Start or reset.
- Signed overflow (DIV 32'h80000000 / 32'hFFFFFFFF): Lo=32'h80000000, Hi=0, DivByZero=0.
- Direct writes WrHi/WrLo:
  - Take effect at the next edge only when Busy=0; ignored while Busy=1.
  - Both may assert together, and both registers receive WrData.
  - If asserted together with an accepted Start, the write occurs and is later overwritten by the result.
- Hi/Lo change only on reset, an accepted direct write, or the FIX edge. They hold their values otherwise, including throughout RUN.

Test Plan:
- Reset, then MULTU OpA=OpB=32'hFFFFFFFF → Busy high 33 cycles; Done pulse; Hi=32'hFFFFFFFE, Lo=32'h00000001.
- MULT OpA=-3 (32'hFFFFFFFD), OpB=7 → Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB. Then immediately DIV OpA=-7, OpB=2, with Start in the Done cycle → Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF.
- DIVU OpA=100, OpB=0 → after 33 cycles Lo=32'hFFFFFFFF, Hi=32'h00000064, DivByZero=1 with Done. DIV 32'h80000000 / 32'hFFFFFFFF → Lo=32'h80000000, Hi=0, DivByZero=0.
- Start MULTU 5*6. Toggle OpA/OpB, pulse Start again, and assert WrHi with WrData=32'hDEADBEEF during cycles 5-10 → all ignored; exactly one Done; Hi=0, Lo=30.
- Start DIVU 1000/7. Drop Reset_n asynchronously mid-cycle at cycle 10 → Hi, Lo, Busy, Done immediately 0. Release reset; no Done ever appears. A new DIVU 1000/7 gives Lo=142, Hi=6.
- In IDLE, WrLo=1 with WrData=32'h12345678 → Lo=32'h12345678 next edge, Hi unchanged. WrHi=WrLo=1 with WrData=32'hA5A5A5A5 → both registers equal 32'hA5A5A5A5.
